regfile_window_reader: RTL

- Read-side sequencer for the 32-entry, 4-read-port register file.
- Treats register contents as a row-major IMG_H x IMG_W feature-map tile (address = row*IMG_W + col).
- Drives all four read addresses each cycle to fetch one 2x2 convolution window. Register-file reads are combinational.
- Captures the window into an output register and streams windows, stride 1, over a valid/ready interface to the MAC array.

---
 rtl/regfile_rd_pkg.sv | 15 +
 rtl/window_addr_gen.sv | 38 +++
 rtl/regfile_window_reader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/regfile_rd_pkg.sv
// Shared types and constants for the register-file window reader.
package regfile_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int NUM_TAPS = 4;
  localparam int RF_DEPTH = 32;
  localparam int COORD_W  = 4;

endpackage

// File: rtl/window_addr_gen.sv
// Combinational tap-address generator for a 2x2 window at origin (row,col).
// Tap-valid bits exist only when REGFILE_WINDOW_READER_PAD_EN is defined.
module window_addr_gen
  import regfile_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int IMG_W      = 4
`ifdef REGFILE_WINDOW_READER_PAD_EN
  ,
  parameter int IMG_H      = 4
`endif
) (
  input  logic [COORD_W-1:0]    row,
  input  logic [COORD_W-1:0]    col,
  output logic [ADDR_WIDTH-1:0] add_1,
  output logic [ADDR_WIDTH-1:0] add_2,
  output logic [ADDR_WIDTH-1:0] add_3,
  output logic [ADDR_WIDTH-1:0] add_4
`ifdef REGFILE_WINDOW_READER_PAD_EN
  ,
  output logic [NUM_TAPS-1:0]   tap_ok
`endif
);

  assign add_1 = ADDR_WIDTH'(32'(row) * IMG_W + 32'(col));
  assign add_2 = ADDR_WIDTH'(32'(row) * IMG_W + 32'(col) + 32'd1);
  assign add_3 = ADDR_WIDTH'((32'(row) + 32'd1) * IMG_W + 32'(col));
  assign add_4 = ADDR_WIDTH'((32'(row) + 32'd1) * IMG_W + 32'(col) + 32'd1);

`ifdef REGFILE_WINDOW_READER_PAD_EN
  // Right column / bottom row taps fall off the tile at the last col / row.
  assign tap_ok[0] = 1'b1;
  assign tap_ok[1] = (32'(col) + 32'd1) < IMG_W;
  assign tap_ok[2] = (32'(row) + 32'd1) < IMG_H;
  assign tap_ok[3] = ((32'(col) + 32'd1) < IMG_W) && ((32'(row) + 32'd1) < IMG_H);
`endif

endmodule

// File: rtl/regfile_window_reader.sv
// Streams stride-1 2x2 windows of a register-file tile over valid/ready.
// Optional zero-padded full scan: REGFILE_WINDOW_READER_PAD_EN.
module regfile_window_reader
  import regfile_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int IMG_W      = 4,
  parameter int IMG_H      = 4
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH-1:0]          rd_add_1,
  output logic [ADDR_WIDTH-1:0]          rd_add_2,
  output logic [ADDR_WIDTH-1:0]          rd_add_3,
  output logic [ADDR_WIDTH-1:0]          rd_add_4,
  input  logic [DATA_WIDTH-1:0]          rd_data_1,
  input  logic [DATA_WIDTH-1:0]          rd_data_2,
  input  logic [DATA_WIDTH-1:0]          rd_data_3,
  input  logic [DATA_WIDTH-1:0]          rd_data_4,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] win_data,
  output logic [COORD_W-1:0]             win_row,
  output logic [COORD_W-1:0]             win_col,
  output logic                           win_last
);

`ifdef REGFILE_WINDOW_READER_PAD_EN
  localparam int LAST_R = IMG_H - 1;
  localparam int LAST_C = IMG_W - 1;
`else
  localparam int LAST_R = IMG_H - 2;
  localparam int LAST_C = IMG_W - 2;
`endif
  localparam logic [COORD_W-1:0] LAST_R_V = COORD_W'(LAST_R);
  localparam logic [COORD_W-1:0] LAST_C_V = COORD_W'(LAST_C);
  localparam logic [COORD_W-1:0] ONE_V    = COORD_W'(1'b1);
  localparam logic [COORD_W-1:0] ZERO_V   = {COORD_W{1'b0}};

  rd_state_e                     state_r, state_nxt;
  logic [COORD_W-1:0]            r_r, c_r, r_nxt, c_nxt;
  logic [ADDR_WIDTH-1:0]         add_1_s, add_2_s, add_3_s, add_4_s;
  logic [NUM_TAPS*DATA_WIDTH-1:0] taps_s;
  logic                          load_s, last_s;

`ifdef REGFILE_WINDOW_READER_PAD_EN
  logic [NUM_TAPS-1:0] tap_ok_s;

  window_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) u_addr (
    .row(r_r), .col(c_r),
    .add_1(add_1_s), .add_2(add_2_s), .add_3(add_3_s), .add_4(add_4_s),
    .tap_ok(tap_ok_s)
  );

  // Out-of-tile taps read address 0 and contribute a zero sample.
  assign rd_add_1 = tap_ok_s[0] ? add_1_s : {ADDR_WIDTH{1'b0}};
  assign rd_add_2 = tap_ok_s[1] ? add_2_s : {ADDR_WIDTH{1'b0}};
  assign rd_add_3 = tap_ok_s[2] ? add_3_s : {ADDR_WIDTH{1'b0}};
  assign rd_add_4 = tap_ok_s[3] ? add_4_s : {ADDR_WIDTH{1'b0}};
  assign taps_s = {tap_ok_s[3] ? rd_data_4 : {DATA_WIDTH{1'b0}},
                   tap_ok_s[2] ? rd_data_3 : {DATA_WIDTH{1'b0}},
                   tap_ok_s[1] ? rd_data_2 : {DATA_WIDTH{1'b0}},
                   tap_ok_s[0] ? rd_data_1 : {DATA_WIDTH{1'b0}}};
`else
  window_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .IMG_W(IMG_W)) u_addr (
    .row(r_r), .col(c_r),
    .add_1(add_1_s), .add_2(add_2_s), .add_3(add_3_s), .add_4(add_4_s)
  );

  assign rd_add_1 = add_1_s;
  assign rd_add_2 = add_2_s;
  assign rd_add_3 = add_3_s;
  assign rd_add_4 = add_4_s;
  assign taps_s   = {rd_data_4, rd_data_3, rd_data_2, rd_data_1};
`endif

  assign load_s = (state_r == RUN) && (!win_valid || win_ready);
  assign last_s = (r_r == LAST_R_V) && (c_r == LAST_C_V);

  // Next-state and column-first counter advance.
  always_comb begin
    state_nxt = state_r;
    r_nxt     = r_r;
    c_nxt     = c_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          r_nxt     = ZERO_V;
          c_nxt     = ZERO_V;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (!load_s) begin
          state_nxt = RUN;
        end else if (last_s) begin
          // Park counters on (0,0) so idle addressing points at the first window.
          state_nxt = DRAIN;
          r_nxt     = ZERO_V;
          c_nxt     = ZERO_V;
        end else if (c_r == LAST_C_V) begin
          c_nxt = ZERO_V;
          r_nxt = r_r + ONE_V;
        end else begin
          c_nxt = c_r + ONE_V;
        end
      end
      DRAIN: begin
        if (win_valid && win_ready) begin
          state_nxt = DONE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and the registered output window.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r   <= IDLE;
      r_r       <= ZERO_V;
      c_r       <= ZERO_V;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_data  <= {(NUM_TAPS*DATA_WIDTH){1'b0}};
      win_row   <= ZERO_V;
      win_col   <= ZERO_V;
    end else begin
      state_r <= state_nxt;
      r_r     <= r_nxt;
      c_r     <= c_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= (state_r == DONE);
      if (load_s) begin
        win_valid <= 1'b1;
        win_data  <= taps_s;
        win_row   <= r_r;
        win_col   <= c_r;
        win_last  <= last_s;
      end else if (win_valid && win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
    end
  end

endmodule
